// File: rtl/mem_pkg.sv
// Shared width encodings, FSM state codes and lane-geometry helpers for the memory access unit.
// Pure definitions: no logic, no latency, no flow control.
package mem_pkg;

  localparam logic [1:0] W_BYTE   = 2'b00;
  localparam logic [1:0] W_HALF   = 2'b01;
  localparam logic [1:0] W_WORD   = 2'b10;
  localparam logic [1:0] W_DOUBLE = 2'b11;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_B0_REQ  = 3'd1;
  localparam logic [2:0] S_B0_WAIT = 3'd2;
  localparam logic [2:0] S_B1_REQ  = 3'd3;
  localparam logic [2:0] S_B1_WAIT = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  function automatic int nb_bytes(input int xlen);
    return xlen / 8;
  endfunction

  function automatic int off_bits(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  function automatic logic [3:0] size_bytes(input logic [1:0] width);
    return 4'd1 << width;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Per-beat lane steering: places store bytes/strobes for beat 0 or 1 and extracts/extends load data.
// Purely combinational, zero latency; no handshake of its own.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = nb_bytes(XLEN),
  localparam int OW = off_bits(XLEN)
) (
  input  logic [OW-1:0]   off,
  input  logic [1:0]      width,
  input  logic            beat1,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_lane,
  output logic [NB-1:0]   st_strb,
  input  logic [XLEN-1:0] ld_b0,
  input  logic [XLEN-1:0] ld_b1,
  output logic [XLEN-1:0] ld_value
);

  logic [3:0]        size;
  logic [XLEN-1:0]   size_mask;
  logic [2*NB-1:0]   strb_wide;
  logic [2*XLEN-1:0] st_wide;
  logic [2*XLEN-1:0] ld_wide;
  logic [XLEN-1:0]   ld_raw;
  logic              sign;

  always_comb begin
    size      = size_bytes(width);
    size_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(size)) size_mask[8*i +: 8] = 8'hFF;
    end

    // Both beats are views of one double-width window shifted by the byte offset.
    strb_wide = (((2*NB)'(1) << size) - (2*NB)'(1)) << off;
    st_wide   = {{XLEN{1'b0}}, st_data & size_mask} << {off, 3'b000};
    st_lane   = beat1 ? st_wide[2*XLEN-1:XLEN] : st_wide[XLEN-1:0];
    st_strb   = beat1 ? strb_wide[2*NB-1:NB]  : strb_wide[NB-1:0];

    ld_wide = {ld_b1, ld_b0} >> {off, 3'b000};
    ld_raw  = ld_wide[XLEN-1:0] & size_mask;
    case (width)
      W_BYTE:  sign = ld_raw[7];
      W_HALF:  sign = ld_raw[15];
      W_WORD:  sign = ld_raw[31];
      default: sign = ld_raw[XLEN-1];
    endcase
    // For full-width loads ~size_mask is zero, so no extension happens.
    ld_value = ld_raw | ({XLEN{sign & ~is_unsigned}} & ~size_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one core request becomes one or two bus beats; >=3 cycles aligned, >=5 split.
// Accepts only when idle; each bus beat held until mem_gnt, completion waits on mem_rvalid.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_unsigned,
  input  logic [1:0]        req_width,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB = nb_bytes(XLEN);
  localparam int OW = off_bits(XLEN);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rd0_q, rd0_d, rdata_q, rdata_d;
  logic [1:0]      width_q, width_d;
  logic            we_q, we_d, uns_q, uns_d, split_q, split_d, err_q, err_d;

  logic [4:0]      end_off;
  logic            misaligned, reject, in_req, beat1;
  logic [XLEN-1:0] beat_addr, lane_wdata, ld_value, ld_b0;
  logic [NB-1:0]   lane_strb;

  always_comb begin
    end_off    = 5'(req_addr[OW-1:0]) + 5'(size_bytes(req_width));
    misaligned = end_off > 5'(NB);
    reject     = (XLEN == 32 && req_width == W_DOUBLE) || (misaligned && !SPLIT_MISALIGNED);

    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    we_d    = we_q;
    uns_d   = uns_q;
    split_d = split_q;
    err_d   = err_q;
    rd0_d   = rd0_q;
    rdata_d = '0;

    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        width_d = req_width;
        we_d    = req_we;
        uns_d   = req_unsigned;
        split_d = misaligned;
        err_d   = reject;
        state_d = reject ? S_RESP : S_B0_REQ;
      end
      S_B0_REQ:  if (mem_gnt) state_d = S_B0_WAIT;
      S_B0_WAIT: if (mem_rvalid) begin
        rd0_d = mem_rdata;
        if (split_q) begin
          state_d = S_B1_REQ;
        end else begin
          state_d = S_RESP;
          rdata_d = we_q ? '0 : ld_value;
        end
      end
      S_B1_REQ:  if (mem_gnt) state_d = S_B1_WAIT;
      S_B1_WAIT: if (mem_rvalid) begin
        state_d = S_RESP;
        rdata_d = we_q ? '0 : ld_value;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= W_BYTE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      rd0_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      split_q <= split_d;
      err_q   <= err_d;
      rd0_q   <= rd0_d;
      rdata_q <= rdata_d;
    end
  end

  // Beat commands derive only from registered state, so they cannot move while waiting for grant.
  always_comb begin
    in_req    = (state_q == S_B0_REQ) || (state_q == S_B1_REQ);
    beat1     = (state_q == S_B1_REQ);
    beat_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}} + (beat1 ? XLEN'(NB) : '0);
    ld_b0     = (state_q == S_B1_WAIT) ? rd0_q : mem_rdata;

    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_err   = (state_q == S_RESP) && err_q;
    rsp_rdata = rdata_q;
    mem_req   = in_req;
    mem_we    = in_req && we_q;
    mem_addr  = in_req ? beat_addr : '0;
    mem_wdata = (in_req && we_q) ? lane_wdata : '0;
    mem_wstrb = in_req ? lane_strb : '0;
  end

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .off         (addr_q[OW-1:0]),
    .width       (width_q),
    .beat1       (beat1),
    .is_unsigned (uns_q),
    .st_data     (wdata_q),
    .st_lane     (lane_wdata),
    .st_strb     (lane_strb),
    .ld_b0       (ld_b0),
    .ld_b1       (mem_rdata),
    .ld_value    (ld_value)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: 32-bit split, 32-bit reject-misaligned and 64-bit split instances
// driven by small bus responders, with hand-computed expectations.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---- instance A: XLEN=32, split ----
  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic [1:0]  a_req_width;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_rsp_valid, a_rsp_err, a_mem_req, a_mem_gnt, a_mem_we, a_mem_rvalid;
  logic [3:0]  a_mem_wstrb;

  mem_access_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_unsigned(a_req_unsigned), .req_width(a_req_width), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err),
    .rsp_rdata(a_rsp_rdata), .mem_req(a_mem_req), .mem_gnt(a_mem_gnt), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata)
  );

  // ---- instance N: XLEN=32, misaligned rejected ----
  logic        n_req_valid, n_req_ready, n_req_we, n_req_unsigned;
  logic [1:0]  n_req_width;
  logic [31:0] n_req_addr, n_req_wdata, n_rsp_rdata, n_mem_addr, n_mem_wdata, n_mem_rdata;
  logic        n_rsp_valid, n_rsp_err, n_mem_req, n_mem_gnt, n_mem_we, n_mem_rvalid;
  logic [3:0]  n_mem_wstrb;

  mem_access_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
    .req_unsigned(n_req_unsigned), .req_width(n_req_width), .req_addr(n_req_addr),
    .req_wdata(n_req_wdata), .rsp_valid(n_rsp_valid), .rsp_err(n_rsp_err),
    .rsp_rdata(n_rsp_rdata), .mem_req(n_mem_req), .mem_gnt(n_mem_gnt), .mem_we(n_mem_we),
    .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .mem_wstrb(n_mem_wstrb),
    .mem_rvalid(n_mem_rvalid), .mem_rdata(n_mem_rdata)
  );

  // ---- instance W: XLEN=64, split ----
  logic        w_req_valid, w_req_ready, w_req_we, w_req_unsigned;
  logic [1:0]  w_req_width;
  logic [63:0] w_req_addr, w_req_wdata, w_rsp_rdata, w_mem_addr, w_mem_wdata, w_mem_rdata;
  logic        w_rsp_valid, w_rsp_err, w_mem_req, w_mem_gnt, w_mem_we, w_mem_rvalid;
  logic [7:0]  w_mem_wstrb;

  mem_access_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we),
    .req_unsigned(w_req_unsigned), .req_width(w_req_width), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata), .rsp_valid(w_rsp_valid), .rsp_err(w_rsp_err),
    .rsp_rdata(w_rsp_rdata), .mem_req(w_mem_req), .mem_gnt(w_mem_gnt), .mem_we(w_mem_we),
    .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_wstrb(w_mem_wstrb),
    .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata)
  );

  // ---- responder A: byte-addressed word memory, programmable grant delay ----
  logic [31:0] a_mem [0:255];
  logic [31:0] a_log_addr[$];
  logic [31:0] a_log_wdata[$];
  logic [3:0]  a_log_strb[$];
  int          a_gnt_delay = 0;
  int          a_wait = 0;
  int          a_unstable = 0;
  bit          a_drop_b1 = 1'b0;
  bit          a_pend = 1'b0;
  logic [31:0] a_pend_data, a_hold_addr, a_hold_wdata;
  logic [3:0]  a_hold_strb;
  logic        a_hold_we;

  initial begin
    for (int i = 0; i < 256; i++) a_mem[i] = 32'h0;
    a_mem[128] = 32'h11223344;  // 0x200
    a_mem[129] = 32'h556677F8;  // 0x204
    a_mem_gnt = 1'b0; a_mem_rvalid = 1'b0; a_mem_rdata = '0;
    forever begin
      @(negedge clk);
      a_mem_gnt = 1'b0; a_mem_rvalid = 1'b0; a_mem_rdata = '0;
      if (!rst_n) begin
        a_pend = 1'b0; a_wait = 0;
      end else begin
        if (a_pend) begin
          a_mem_rvalid = 1'b1; a_mem_rdata = a_pend_data; a_pend = 1'b0;
        end
        if (a_mem_req) begin
          if (a_wait == 0) begin
            a_hold_addr = a_mem_addr; a_hold_wdata = a_mem_wdata;
            a_hold_strb = a_mem_wstrb; a_hold_we = a_mem_we;
          end else if (a_mem_addr !== a_hold_addr || a_mem_wdata !== a_hold_wdata ||
                       a_mem_wstrb !== a_hold_strb || a_mem_we !== a_hold_we) begin
            a_unstable++;
          end
          if (a_wait >= a_gnt_delay) begin
            a_mem_gnt = 1'b1; a_wait = 0;
            a_log_addr.push_back(a_mem_addr);
            a_log_wdata.push_back(a_mem_wdata);
            a_log_strb.push_back(a_mem_wstrb);
            if (a_mem_we)
              for (int b = 0; b < 4; b++)
                if (a_mem_wstrb[b]) a_mem[a_mem_addr[9:2]][8*b +: 8] = a_mem_wdata[8*b +: 8];
            a_pend_data = a_mem[a_mem_addr[9:2]];
            a_pend = !(a_drop_b1 && a_log_addr.size() == 2);
          end else begin
            a_wait++;
          end
        end
      end
    end
  end

  // ---- responder W: two 64-bit words, at 0x0 and at the top of memory ----
  logic [63:0] w_log_addr[$];
  bit          w_pend = 1'b0;
  logic [63:0] w_pend_data;

  initial begin
    w_mem_gnt = 1'b0; w_mem_rvalid = 1'b0; w_mem_rdata = '0;
    forever begin
      @(negedge clk);
      w_mem_gnt = 1'b0; w_mem_rvalid = 1'b0; w_mem_rdata = '0;
      if (!rst_n) begin
        w_pend = 1'b0;
      end else begin
        if (w_pend) begin
          w_mem_rvalid = 1'b1; w_mem_rdata = w_pend_data; w_pend = 1'b0;
        end
        if (w_mem_req) begin
          w_mem_gnt = 1'b1;
          w_log_addr.push_back(w_mem_addr);
          w_pend_data = (w_mem_addr == 64'h0) ? 64'h000000000000C3B2 : 64'h8899AABBCCDDEEFF;
          w_pend = 1'b1;
        end
      end
    end
  end

  // Instance N must never issue a beat.
  bit n_req_seen = 1'b0;
  initial begin
    n_mem_gnt = 1'b0; n_mem_rvalid = 1'b0; n_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (n_mem_req) n_req_seen = 1'b1;
    end
  end

  // ---- request drivers: return cycles from acceptance to rsp_valid ----
  task automatic a_xfer(input logic we, input logic uns, input logic [1:0] w,
                        input logic [31:0] addr, input logic [31:0] data,
                        output int lat, output logic err, output logic [31:0] rd);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_unsigned = uns;
    a_req_width = w; a_req_addr = addr; a_req_wdata = data;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_we = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!a_rsp_valid && lat < 60);
    err = a_rsp_err; rd = a_rsp_rdata;
  endtask

  task automatic n_xfer(input logic [1:0] w, input logic [31:0] addr,
                        output int lat, output logic err, output logic [31:0] rd);
    @(negedge clk);
    n_req_valid = 1'b1; n_req_we = 1'b0; n_req_unsigned = 1'b0;
    n_req_width = w; n_req_addr = addr; n_req_wdata = '0;
    @(posedge clk); #1;
    n_req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!n_rsp_valid && lat < 60);
    err = n_rsp_err; rd = n_rsp_rdata;
  endtask

  task automatic w_xfer(input logic uns, input logic [1:0] w, input logic [63:0] addr,
                        output int lat, output logic err, output logic [63:0] rd);
    @(negedge clk);
    w_req_valid = 1'b1; w_req_we = 1'b0; w_req_unsigned = uns;
    w_req_width = w; w_req_addr = addr; w_req_wdata = '0;
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!w_rsp_valid && lat < 60);
    err = w_rsp_err; rd = w_rsp_rdata;
  endtask

  task automatic clear_logs();
    a_log_addr.delete(); a_log_wdata.delete(); a_log_strb.delete(); w_log_addr.delete();
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", a_req_ready); end
    checks++; if ({a_rsp_valid, a_rsp_err} !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b expected 00", {a_rsp_valid, a_rsp_err}); end
    checks++; if (a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", a_rsp_rdata); end
    checks++; if ({a_mem_req, a_mem_we, a_mem_wstrb} !== 6'b0) begin errors++; $display("FAIL reset_mem_ctl: got %b expected 0", {a_mem_req, a_mem_we, a_mem_wstrb}); end
    checks++; if ({a_mem_addr, a_mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_bus: got %h expected 0", {a_mem_addr, a_mem_wdata}); end
    checks++; if ({n_req_ready, w_req_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready_nw: got %b expected 11", {n_req_ready, w_req_ready}); end
  endtask

  task automatic test_store_byte();
    int lat; logic err; logic [31:0] rd;
    clear_logs();
    a_xfer(1'b1, 1'b0, 2'b00, 32'h103, 32'hAB, lat, err, rd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", lat); end
    checks++; if ({err, rd} !== 33'h0) begin errors++; $display("FAIL sb_rsp: got err=%b rdata=%h expected 0/0", err, rd); end
    checks++; if (a_log_addr.size() != 1) begin errors++; $display("FAIL sb_beats: got %0d expected 1", a_log_addr.size()); end
    else begin
      checks++; if (a_log_addr[0] !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h expected 100", a_log_addr[0]); end
      checks++; if (a_log_strb[0] !== 4'b1000) begin errors++; $display("FAIL sb_strb: got %b expected 1000", a_log_strb[0]); end
      checks++; if (a_log_wdata[0][31:24] !== 8'hAB) begin errors++; $display("FAIL sb_wdata: got %h expected AB", a_log_wdata[0][31:24]); end
    end
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_pulse_width: got %b expected 0", a_rsp_valid); end
  endtask

  task automatic test_split_load();
    int lat; logic err; logic [31:0] rd;
    clear_logs();
    a_xfer(1'b0, 1'b0, 2'b01, 32'h203, 32'h0, lat, err, rd);
    checks++; if (lat !== 5) begin errors++; $display("FAIL lh_split_latency: got %0d expected 5", lat); end
    checks++; if ({err, rd} !== {1'b0, 32'hFFFFF811}) begin errors++; $display("FAIL lh_split_data: got err=%b rdata=%h expected 0/FFFFF811", err, rd); end
    checks++; if (a_log_addr.size() != 2) begin errors++; $display("FAIL lh_split_beats: got %0d expected 2", a_log_addr.size()); end
    else begin
      checks++; if ({a_log_addr[0], a_log_addr[1]} !== {32'h200, 32'h204}) begin errors++; $display("FAIL lh_split_addr: got %h %h expected 200 204", a_log_addr[0], a_log_addr[1]); end
    end
    a_xfer(1'b0, 1'b1, 2'b01, 32'h203, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'h0000F811) begin errors++; $display("FAIL lhu_split: got %h expected 0000F811", rd); end
    a_xfer(1'b0, 1'b0, 2'b00, 32'h204, 32'h0, lat, err, rd);
    checks++; if ({lat, rd} !== {32'd3, 32'hFFFFFFF8}) begin errors++; $display("FAIL lb_sext: got lat=%0d rdata=%h expected 3/FFFFFFF8", lat, rd); end
    a_xfer(1'b0, 1'b1, 2'b00, 32'h204, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'h000000F8) begin errors++; $display("FAIL lbu_zext: got %h expected 000000F8", rd); end
    a_xfer(1'b0, 1'b0, 2'b10, 32'h200, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL lw_aligned: got %h expected 11223344", rd); end
  endtask

  task automatic test_split_store();
    int lat; logic err; logic [31:0] rd;
    clear_logs();
    a_xfer(1'b1, 1'b0, 2'b10, 32'h0FE, 32'hDEADBEEF, lat, err, rd);
    checks++; if ({lat, err} !== {32'd5, 1'b0}) begin errors++; $display("FAIL sw_split_rsp: got lat=%0d err=%b expected 5/0", lat, err); end
    checks++; if (a_log_addr.size() != 2) begin errors++; $display("FAIL sw_split_beats: got %0d expected 2", a_log_addr.size()); end
    else begin
      checks++; if ({a_log_addr[0], a_log_strb[0], a_log_wdata[0][31:16]} !== {32'h0FC, 4'b1100, 16'hBEEF}) begin errors++; $display("FAIL sw_beat0: got addr=%h strb=%b data=%h expected 0FC/1100/BEEF", a_log_addr[0], a_log_strb[0], a_log_wdata[0][31:16]); end
      checks++; if ({a_log_addr[1], a_log_strb[1], a_log_wdata[1][15:0]} !== {32'h100, 4'b0011, 16'hDEAD}) begin errors++; $display("FAIL sw_beat1: got addr=%h strb=%b data=%h expected 100/0011/DEAD", a_log_addr[1], a_log_strb[1], a_log_wdata[1][15:0]); end
    end
    a_xfer(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'hAB00DEAD) begin errors++; $display("FAIL sw_no_overwrite: got %h expected AB00DEAD", rd); end
    a_xfer(1'b0, 1'b0, 2'b10, 32'h0FE, 32'h0, lat, err, rd);
    checks++; if ({lat, rd} !== {32'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL lw_split_roundtrip: got lat=%0d rdata=%h expected 5/DEADBEEF", lat, rd); end
  endtask

  task automatic test_gnt_delay();
    int lat; logic err; logic [31:0] rd;
    clear_logs();
    a_unstable = 0; a_gnt_delay = 4;
    a_xfer(1'b1, 1'b0, 2'b01, 32'h102, 32'h1234, lat, err, rd);
    a_gnt_delay = 0;
    checks++; if (lat !== 7) begin errors++; $display("FAIL gnt_delay_latency: got %0d expected 7", lat); end
    checks++; if (a_unstable !== 0) begin errors++; $display("FAIL gnt_delay_stable: got %0d changes expected 0", a_unstable); end
    a_xfer(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, lat, err, rd);
    checks++; if (rd !== 32'h1234DEAD) begin errors++; $display("FAIL sh_delayed_data: got %h expected 1234DEAD", rd); end
  endtask

  task automatic test_errors();
    int lat; logic err; logic [31:0] rd;
    clear_logs();
    a_xfer(1'b0, 1'b0, 2'b11, 32'h100, 32'h0, lat, err, rd);
    checks++; if ({lat, err, rd} !== {32'd1, 1'b1, 32'h0}) begin errors++; $display("FAIL ld32_err: got lat=%0d err=%b rdata=%h expected 1/1/0", lat, err, rd); end
    checks++; if (a_log_addr.size() != 0) begin errors++; $display("FAIL ld32_no_beat: got %0d beats expected 0", a_log_addr.size()); end
    n_xfer(2'b10, 32'h001, lat, err, rd);
    checks++; if ({lat, err, rd} !== {32'd1, 1'b1, 32'h0}) begin errors++; $display("FAIL nosplit_err: got lat=%0d err=%b rdata=%h expected 1/1/0", lat, err, rd); end
    n_xfer(2'b11, 32'h000, lat, err, rd);
    checks++; if ({lat, err} !== {32'd1, 1'b1}) begin errors++; $display("FAIL nosplit_ld_err: got lat=%0d err=%b expected 1/1", lat, err); end
    checks++; if (n_req_seen !== 1'b0) begin errors++; $display("FAIL nosplit_no_mem_req: got %b expected 0", n_req_seen); end
  endtask

  task automatic test_reset_mid();
    int lat; int seen; logic err; logic [31:0] rd;
    clear_logs();
    a_drop_b1 = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_unsigned = 1'b0;
    a_req_width = 2'b10; a_req_addr = 32'h0FE;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({a_log_addr.size() == 2, a_mem_req, a_rsp_valid} !== 3'b100) begin errors++; $display("FAIL mid_in_b1_wait: got beats=%0d mem_req=%b rsp_valid=%b expected 2/0/0", a_log_addr.size(), a_mem_req, a_rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if ({a_req_ready, a_mem_req} !== 2'b10) begin errors++; $display("FAIL mid_async_reset: got ready/mem_req=%b expected 10", {a_req_ready, a_mem_req}); end
    @(negedge clk);
    rst_n = 1'b1; a_drop_b1 = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (a_rsp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d pulses expected 0", seen); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", a_req_ready); end
    a_xfer(1'b0, 1'b0, 2'b00, 32'h203, 32'h0, lat, err, rd);
    checks++; if ({lat, rd} !== {32'd3, 32'h00000011}) begin errors++; $display("FAIL mid_recover: got lat=%0d rdata=%h expected 3/00000011", lat, rd); end
  endtask

  task automatic test_wrap64();
    int lat; logic err; logic [63:0] rd;
    clear_logs();
    w_xfer(1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, lat, err, rd);
    checks++; if ({lat, err, rd} !== {32'd5, 1'b0, 64'h00000000C3B28899}) begin errors++; $display("FAIL lwu_wrap: got lat=%0d err=%b rdata=%h expected 5/0/00000000C3B28899", lat, err, rd); end
    checks++; if (w_log_addr.size() != 2) begin errors++; $display("FAIL wrap_beats: got %0d expected 2", w_log_addr.size()); end
    else begin
      checks++; if ({w_log_addr[0], w_log_addr[1]} !== {64'hFFFF_FFFF_FFFF_FFF8, 64'h0}) begin errors++; $display("FAIL wrap_addr: got %h %h expected FFFFFFFFFFFFFFF8 0", w_log_addr[0], w_log_addr[1]); end
    end
    w_xfer(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, lat, err, rd);
    checks++; if (rd !== 64'hFFFFFFFFC3B28899) begin errors++; $display("FAIL lw_wrap_sext: got %h expected FFFFFFFFC3B28899", rd); end
    w_xfer(1'b0, 2'b11, 64'h0, lat, err, rd);
    checks++; if ({lat, err, rd} !== {32'd3, 1'b0, 64'h000000000000C3B2}) begin errors++; $display("FAIL ld64_aligned: got lat=%0d err=%b rdata=%h expected 3/0/C3B2", lat, err, rd); end
  endtask

  initial begin
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_unsigned = 1'b0; a_req_width = 2'b00;
    a_req_addr = '0; a_req_wdata = '0;
    n_req_valid = 1'b0; n_req_we = 1'b0; n_req_unsigned = 1'b0; n_req_width = 2'b00;
    n_req_addr = '0; n_req_wdata = '0;
    w_req_valid = 1'b0; w_req_we = 1'b0; w_req_unsigned = 1'b0; w_req_width = 2'b00;
    w_req_addr = '0; w_req_wdata = '0;
    test_reset();
    test_store_byte();
    test_split_load();
    test_split_store();
    test_gnt_delay();
    test_errors();
    test_reset_mid();
    test_wrap64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter XLEN, default 32, meaning data/address width; legal values 32 and 64.
REQ-002 Parameter SPLIT_MISALIGNED, default 1, meaning 1 = split misaligned accesses into two bus beats, 0 = reject them with error.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port req_valid / req_ready  in / out  1 / 1  core request handshake.
REQ-006 Port req_we, req_unsigned  in  1 each  store select; zero-extend select for loads.
REQ-007 Port req_width  in  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64).
REQ-008 Port req_addr, req_wdata  in  XLEN each  byte address; store data, right-aligned.
REQ-009 Port rsp_valid, rsp_err  out  1 each  one-cycle completion pulse; error flag.
REQ-010 Port rsp_rdata  out  XLEN  aligned, extended load data; zero for stores and errors.
REQ-011 Port mem_req / mem_gnt  out / in  1 / 1  bus beat request and grant.
REQ-012 Port mem_we, mem_addr, mem_wdata, mem_wstrb  out  1, XLEN, XLEN, XLEN/8  beat command, word-aligned address, lane-placed data, byte strobes.
REQ-013 Port mem_rvalid, mem_rdata  in  1, XLEN  beat acknowledge (reads and writes) with read data.

Function
REQ-014 NB = XLEN/8, off = req_addr mod NB, size = 1<<req_width; access is misaligned when off+size > NB.
REQ-015 FSM states IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; request accepted when req_valid & req_ready; address, width, data, flags registered at acceptance.
REQ-017 IDLE -> RESP with rsp_err=1 and no bus beat when req_width=11 with XLEN=32, or misaligned with SPLIT_MISALIGNED=0.
REQ-018 Otherwise IDLE -> B0_REQ; mem_req held 1 in B0_REQ/B1_REQ until mem_gnt; all mem_* outputs stable while mem_req=1 and mem_gnt=0.
REQ-019 Beat 0: mem_addr = addr with low log2(NB) bits cleared; strobes bytes off..min(off+size,NB)-1; wdata shifted left by 8*off.
REQ-020 Beat 1 (misaligned only): mem_addr = beat-0 address + NB, wrapping modulo 2^XLEN; strobes bytes 0..off+size-NB-1; wdata carries remaining upper bytes in lane 0 upward.
REQ-021 B0_REQ -> B0_WAIT on mem_gnt; B0_WAIT -> B1_REQ (misaligned) or RESP (aligned) on mem_rvalid; B1_REQ -> B1_WAIT on mem_gnt; B1_WAIT -> RESP on mem_rvalid.
REQ-022 mem_rvalid in same cycle as mem_gnt SHALL not be accepted; ack only counts in *_WAIT states.
REQ-023 Load data: beat-0 bytes off..NB-1 and beat-1 bytes form a contiguous value; result sign-extended from bit 8*size-1 unless req_unsigned or size=NB.
REQ-024 RESP lasts exactly one cycle with rsp_valid=1, then IDLE; minimum latency acceptance-to-rsp_valid = 3 cycles aligned with gnt and rvalid immediate, 5 cycles split.
REQ-025 Stores SHALL never write bytes outside the requested range; mem_wstrb = 0 whenever mem_req = 0.

Reset
REQ-026 rst_n low SHALL force IDLE asynchronously, mid-transaction included, dropping any pending beat without response.
REQ-027 Reset values: req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.

Structure
REQ-028 Width encodings, FSM state encoding and the NB/off helper constants SHALL live in shared package mem_pkg.
REQ-029 One sub-module mem_lane_align (combinational shift/strobe/extend for one beat) SHALL be instantiated for store placement and load extraction.

Verification
REQ-030 XLEN=32, sb addr 0x103 data 0xAB -> one beat, addr 0x100, wstrb 1000, wdata[31:24]=0xAB, rsp_valid, rsp_err=0.
REQ-031 XLEN=32, lh addr 0x203, mem word@0x200=0x11223344, @0x204=0x556677F8 -> two beats, rsp_rdata=0xFFFFF811.
REQ-032 XLEN=32, sw addr 0x0FE data 0xDEADBEEF -> beat0 addr 0x0FC wstrb 1100 bytes EF,BE; beat1 addr 0x100 wstrb 0011 bytes AD,DE.
REQ-033 SPLIT_MISALIGNED=0, lw addr 0x001 -> no mem_req, rsp_valid with rsp_err=1 on cycle 2; XLEN=32 width 11 -> same.
REQ-034 mem_gnt delayed 4 cycles -> mem_* outputs constant throughout; rst_n pulsed low in B1_WAIT -> IDLE, no rsp_valid, req_ready=1 next cycle.
REQ-035 XLEN=64, lwu addr 0xFFFF_FFFF_FFFF_FFFE -> beat1 addr wraps to 0x0, result zero-extended.
